// File: rtl/mem_arb_pkg.sv
// Shared types for the memory access arbiter: one-hot FSM states and the
// round-robin grant marker.
package mem_arb_pkg;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    CPU_CMD = 5'b00010,
    CPU_ACC = 5'b00100,
    CPU_END = 5'b01000,
    DMA_ACC = 5'b10000
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } grant_t;

  localparam int unsigned WaitCntW = 4;

endpackage

// File: rtl/wait_state_counter.sv
// Load/decrement access-cycle counter; last is high on the final cycle of an access.
module wait_state_counter
  import mem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                dec,
  input  logic [WaitCntW-1:0] load_val,
  output logic                last
);

  logic [WaitCntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one memory/IO datapath between the 8088 bus and a DMA requester, generating
// LA/OE/WE strobes, the address/data mux select and CPU READY throttling.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 19,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned DMA_BURST   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ale,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic                  cs,
  output logic                  ready,
  input  logic                  dma_req,
  input  logic                  dma_wr,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  output logic                  dma_gnt,
  output logic                  dma_done,
  output logic                  la,
  output logic                  oe,
  output logic                  we,
  output logic                  sel_dma,
  output logic [ADDR_WIDTH-1:0] dp_dma_addr
);

  localparam int unsigned         BurstW   = $clog2(DMA_BURST + 1);
  localparam logic [BurstW-1:0]   BurstMax = BurstW'(DMA_BURST);
  localparam logic [WaitCntW-1:0] WaitLoad = WaitCntW'(WAIT_STATES);
  // With zero wait states the CPU is never stalled while waiting for its strobe.
  localparam logic                CmdHold  = (WAIT_STATES != 0);

  state_t            state_q;
  grant_t            last_grant_q;
  logic              cpu_pend_q, cpu_pend_d;
  logic [BurstW-1:0] burst_q;
  logic              is_read_q;
  logic              dma_wr_q;

  logic cpu_req, cpu_win, idle_cpu, idle_dma, strobe;
  logic cnt_load, cnt_dec, cnt_last;

  always_comb begin
    cpu_req    = (cs & ale) | cpu_pend_q;
    cpu_win    = cpu_req & (~dma_req | (last_grant_q == GNT_DMA) | (burst_q == BurstMax));
    // Mealy grant decisions are masked during reset so LA/GNT stay low.
    idle_cpu   = rst_n & (state_q == IDLE) & cpu_win;
    idle_dma   = rst_n & (state_q == IDLE) & ~cpu_win & dma_req;
    strobe     = ~rd_n | ~wr_n;
    cpu_pend_d = idle_cpu ? 1'b0 : (cpu_pend_q | (cs & ale));
    cnt_load   = idle_dma | ((state_q == CPU_CMD) & strobe);
    cnt_dec    = (state_q == CPU_ACC) | (state_q == DMA_ACC);
  end

  wait_state_counter u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WaitLoad),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_DMA;
      cpu_pend_q   <= 1'b0;
      burst_q      <= '0;
      is_read_q    <= 1'b0;
      dma_wr_q     <= 1'b0;
      dp_dma_addr  <= '0;
    end else begin
      cpu_pend_q <= cpu_pend_d;
      unique case (state_q)
        IDLE: begin
          if (idle_cpu) begin
            state_q <= CPU_CMD;
          end else if (idle_dma) begin
            state_q     <= DMA_ACC;
            dma_wr_q    <= dma_wr;
            dp_dma_addr <= dma_addr;
          end
        end
        CPU_CMD: begin
          if (strobe) begin
            state_q   <= CPU_ACC;
            is_read_q <= ~rd_n;
          end
        end
        CPU_ACC: begin
          if (cnt_last) begin
            state_q      <= CPU_END;
            last_grant_q <= GNT_CPU;
            burst_q      <= '0;
          end
        end
        CPU_END: begin
          // Hold until the bus cycle ends so one strobe never triggers two accesses.
          if (rd_n && wr_n) state_q <= IDLE;
        end
        DMA_ACC: begin
          if (cnt_last) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_DMA;
            if (cpu_pend_q && (burst_q != BurstMax)) burst_q <= burst_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    la       = idle_cpu | idle_dma;
    dma_gnt  = idle_dma;
    sel_dma  = idle_dma | (state_q == DMA_ACC);
    oe       = ((state_q == CPU_ACC) & is_read_q) | ((state_q == DMA_ACC) & ~dma_wr_q);
    we       = cnt_last & (((state_q == CPU_ACC) & ~is_read_q) |
                           ((state_q == DMA_ACC) & dma_wr_q));
    dma_done = cnt_last & (state_q == DMA_ACC);
    ready    = ~(cpu_pend_q | ((state_q == CPU_CMD) & CmdHold) |
                 ((state_q == CPU_ACC) & ~cnt_last));
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed literal checks, then random bus/DMA traffic
// compared every cycle against a transaction-phase reference model.
module tb_mem_access_arbiter;

  localparam int unsigned AW    = 19;
  localparam int unsigned WS    = 1;
  localparam int unsigned BURST = 4;

  localparam int PhFree    = 0;
  localparam int PhCpuAddr = 1;
  localparam int PhCpuXfer = 2;
  localparam int PhCpuHold = 3;
  localparam int PhDmaXfer = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          ale = 1'b0, rd_n = 1'b1, wr_n = 1'b1, cs = 1'b0;
  logic          dma_req = 1'b0, dma_wr = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic          ready, dma_gnt, dma_done, la, oe, we, sel_dma;
  logic [AW-1:0] dp_dma_addr;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  mem_access_arbiter #(
    .ADDR_WIDTH  (AW),
    .WAIT_STATES (WS),
    .DMA_BURST   (BURST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ale         (ale),
    .rd_n        (rd_n),
    .wr_n        (wr_n),
    .cs          (cs),
    .ready       (ready),
    .dma_req     (dma_req),
    .dma_wr      (dma_wr),
    .dma_addr    (dma_addr),
    .dma_gnt     (dma_gnt),
    .dma_done    (dma_done),
    .la          (la),
    .oe          (oe),
    .we          (we),
    .sel_dma     (sel_dma),
    .dp_dma_addr (dp_dma_addr)
  );

  // Reference model: current transaction phase plus elapsed access cycles.
  int            m_phase = PhFree, m_k = 0, m_words = 0;
  bit            m_pend = 0, m_last_dma = 1, m_rd = 0, m_dwr = 0;
  logic [AW-1:0] m_addr = '0;
  int            n_phase, n_k, n_words;
  bit            n_pend, n_last_dma, n_rd, n_dwr;
  logic [AW-1:0] n_addr;
  bit            e_ready, e_la, e_oe, e_we, e_sel, e_gnt, e_done;
  bit            s_gnt, s_done;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit last, cpu_turn;
    last     = (m_k == int'(WS));
    cpu_turn = 0;
    n_phase = m_phase; n_k = m_k; n_words = m_words; n_last_dma = m_last_dma;
    n_rd = m_rd; n_dwr = m_dwr; n_addr = m_addr; n_pend = m_pend;
    e_ready = 1; e_la = 0; e_oe = 0; e_we = 0; e_sel = 0; e_gnt = 0; e_done = 0;
    if (!rst_n) begin
      n_phase = PhFree; n_k = 0; n_words = 0; n_last_dma = 1; n_pend = 0;
    end else begin
      case (m_phase)
        PhFree: begin
          cpu_turn = ((cs && ale) || m_pend) && (!dma_req || m_last_dma || m_words == BURST);
          if (cpu_turn) begin
            e_la = 1; n_phase = PhCpuAddr;
          end else if (dma_req) begin
            e_la = 1; e_sel = 1; e_gnt = 1;
            n_phase = PhDmaXfer; n_k = 0; n_dwr = dma_wr; n_addr = dma_addr;
          end
        end
        PhCpuAddr: if (!rd_n || !wr_n) begin n_phase = PhCpuXfer; n_k = 0; n_rd = !rd_n; end
        PhCpuXfer: begin
          e_oe = m_rd; e_we = !m_rd && last; n_k = m_k + 1;
          if (last) begin n_phase = PhCpuHold; n_words = 0; n_last_dma = 0; end
        end
        PhCpuHold: if (rd_n && wr_n) n_phase = PhFree;
        default: begin
          e_sel = 1; e_oe = !m_dwr; e_we = m_dwr && last; e_done = last; n_k = m_k + 1;
          if (last) begin
            n_phase = PhFree; n_last_dma = 1;
            if (m_pend && m_words < int'(BURST)) n_words = m_words + 1;
          end
        end
      endcase
      n_pend  = cpu_turn ? 0 : (m_pend || (cs && ale));
      e_ready = !(m_pend || (m_phase == PhCpuAddr && WS != 0) || (m_phase == PhCpuXfer && !last));
    end
    s_gnt = dma_gnt; s_done = dma_done;
    check("ready", ready, e_ready);
    check("la", la, e_la);
    check("oe", oe, e_oe);
    check("we", we, e_we);
    check("sel_dma", sel_dma, e_sel);
    check("dma_gnt", dma_gnt, e_gnt);
    check("dma_done", dma_done, e_done);
    if (rst_n && m_phase == PhDmaXfer) check("dp_dma_addr", dp_dma_addr, m_addr);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PhFree; m_k <= 0; m_words <= 0; m_last_dma <= 1; m_pend <= 0;
      m_rd <= 0; m_dwr <= 0; m_addr <= '0;
    end else begin
      m_phase <= n_phase; m_k <= n_k; m_words <= n_words; m_last_dma <= n_last_dma;
      m_pend <= n_pend; m_rd <= n_rd; m_dwr <= n_dwr; m_addr <= n_addr;
    end
  end

  initial forever begin
    @(negedge clk);
    model_step();
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pin(input string nm, input logic act, input bit mdl, input logic lit);
    check({nm, "_dut"}, act, lit);
    check({nm, "_model"}, mdl, lit);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_agent(input int end_cyc);
    int w;
    while (cycle < end_cyc) begin
      cyc();
      if ($urandom_range(0, 2) == 0) begin
        cs  = ($urandom_range(0, 5) != 0);
        ale = 1'b1;
        cyc();
        ale = 1'b0;
        if ($urandom_range(0, 1) == 1) rd_n = 1'b0; else wr_n = 1'b0;
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!ready && w < 200);
        check("bus_ready_wait", (w < 200), 1);
        repeat ($urandom_range(0, 2)) cyc();
        cyc();
        rd_n = 1'b1; wr_n = 1'b1; cs = 1'b0;
      end
    end
  endtask

  task automatic dma_agent(input int end_cyc);
    bit granted;
    granted = 0;
    while (cycle < end_cyc) begin
      cyc();
      if (!dma_req) begin
        if ($urandom_range(0, 3) == 0) begin
          dma_req  = 1'b1;
          dma_wr   = 1'($urandom_range(0, 1));
          dma_addr = AW'($urandom);
          granted  = 0;
        end
      end else begin
        if (s_gnt) granted = 1;
        if (s_done || (!granted && $urandom_range(0, 40) == 0) ||
            (granted && $urandom_range(0, 30) == 0)) dma_req = 1'b0;
      end
    end
    dma_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();
    settle();
    pin("reset_ready", ready, e_ready, 1'b1);
    pin("reset_sel", sel_dma, e_sel, 1'b0);

    // CPU read, no DMA: LA in the ALE cycle, OE for two access cycles.
    cyc(); cs = 1'b1; ale = 1'b1;
    settle();
    pin("rd_la", la, e_la, 1'b1);
    pin("rd_la_sel", sel_dma, e_sel, 1'b0);
    pin("rd_la_ready", ready, e_ready, 1'b1);
    cyc(); ale = 1'b0; cs = 1'b0; rd_n = 1'b0;
    settle();
    pin("rd_cmd_ready", ready, e_ready, 1'b0);
    pin("rd_cmd_oe", oe, e_oe, 1'b0);
    cyc(); settle();
    pin("rd_acc0_oe", oe, e_oe, 1'b1);
    pin("rd_acc0_ready", ready, e_ready, 1'b0);
    cyc(); settle();
    pin("rd_acc1_oe", oe, e_oe, 1'b1);
    pin("rd_acc1_ready", ready, e_ready, 1'b1);
    pin("rd_acc1_we", we, e_we, 1'b0);
    cyc(); rd_n = 1'b1;
    settle();
    pin("rd_end_oe", oe, e_oe, 1'b0);
    cyc();

    // DMA write of a word at 0x00020.
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = AW'(32'h20);
    settle();
    pin("dma_gnt", dma_gnt, e_gnt, 1'b1);
    pin("dma_gnt_sel", sel_dma, e_sel, 1'b1);
    cyc(); settle();
    pin("dma_acc0_we", we, e_we, 1'b0);
    pin("dma_acc0_done", dma_done, e_done, 1'b0);
    cyc(); settle();
    pin("dma_acc1_we", we, e_we, 1'b1);
    pin("dma_acc1_done", dma_done, e_done, 1'b1);
    check("dma_addr_lat", dp_dma_addr, 32'h20);
    cyc(); dma_req = 1'b0;
    settle();
    pin("dma_idle_sel", sel_dma, e_sel, 1'b0);

    // Reset asserted on the final cycle of a CPU write.
    cyc(); cs = 1'b1; ale = 1'b1;
    cyc(); cs = 1'b0; ale = 1'b0; wr_n = 1'b0;
    cyc(); cyc();
    check("wr_last_we", we, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_we", we, 0);
    check("rst_async_oe", oe, 0);
    check("rst_async_ready", ready, 1);
    wr_n = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); settle();
    pin("post_rst_we", we, e_we, 1'b0);
    pin("post_rst_la", la, e_la, 1'b0);

    fork
      bus_agent(cycle + 4000);
      dma_agent(cycle + 4000);
    join
    cyc();
    ale = 1'b0; cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1; dma_req = 1'b0;
    repeat (20) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
